// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with an integrated transmit FIFO.
// Frames are start bit, DATA_WIDTH data bits (LSB first), an optional parity bit and
// STOP_BITS stop bits. Bytes queue in a FIFO_DEPTH-entry FIFO and go out back-to-back,
// with one idle clock between frames.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   din        write data, sampled only when the write is accepted
//   wr_en      push din into the FIFO this cycle
//   full       FIFO holds FIFO_DEPTH entries
//   fifo_count current FIFO occupancy
//   overflow   high in any cycle where a write is dropped because the FIFO is full
//   tx         serial line, idle high
//   tx_busy    frame in progress
//   tx_done    one-cycle pulse in the first idle cycle after each frame
module uart_tx_fifo #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned BAUD_RATE   = 9600,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned PARITY      = 0,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         din,
    input  logic                          wr_en,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          tx_done
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W        = $clog2(STOP_BITS * CLKS_PER_BIT + 1);
    localparam int unsigned BIT_W        = $clog2(DATA_WIDTH);

    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_END = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);
    localparam logic [PTR_W:0]   DEPTH_V  = (PTR_W + 1)'(FIFO_DEPTH);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("uart_tx_fifo: CLK_FREQ_HZ / BAUD_RATE must be at least 2");
        end
        if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
            $error("uart_tx_fifo: DATA_WIDTH must be 5..9");
        end
        if (PARITY > 2) begin : g_bad_parity
            $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2, at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [PTR_W:0]          count_next;
    logic                    push;
    logic                    pop;
    logic [DATA_WIDTH-1:0]   shift;
    logic                    par_bit;
    logic [CNT_W-1:0]        baud_cnt;
    logic [BIT_W-1:0]        bit_cnt;

    assign push     = wr_en && !full;
    // A dropped write is flagged even when a pop frees a slot in the same cycle.
    assign overflow = wr_en && full;
    assign pop      = (state == StIdle) && (fifo_count != '0);

    always_comb begin
        count_next = fifo_count;
        if (push && !pop) begin
            count_next = fifo_count + 1'b1;
        end else if (!push && pop) begin
            count_next = fifo_count - 1'b1;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            full       <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_count <= count_next;
            full       <= (count_next == DEPTH_V);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= StIdle;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
            shift    <= '0;
            par_bit  <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            tx_done <= 1'b0;
            unique case (state)
                StIdle: begin
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                    if (pop) begin
                        shift    <= mem[rd_ptr];
                        // Odd parity makes the total count of ones odd, even makes it even.
                        par_bit  <= (PARITY == 1) ? ~^mem[rd_ptr] : ^mem[rd_ptr];
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx       <= 1'b0;
                        tx_busy  <= 1'b1;
                        state    <= StStart;
                    end
                end
                StStart: begin
                    if (baud_cnt == BIT_END) begin
                        baud_cnt <= '0;
                        tx       <= shift[0];
                        state    <= StData;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                StData: begin
                    if (baud_cnt == BIT_END) begin
                        baud_cnt <= '0;
                        if (bit_cnt == LAST_BIT) begin
                            if (PARITY != 0) begin
                                tx    <= par_bit;
                                state <= StParity;
                            end else begin
                                tx    <= 1'b1;
                                state <= StStop;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                StParity: begin
                    if (baud_cnt == BIT_END) begin
                        baud_cnt <= '0;
                        tx       <= 1'b1;
                        state    <= StStop;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                StStop: begin
                    // One counter span covers all stop bits.
                    if (baud_cnt == STOP_END) begin
                        baud_cnt <= '0;
                        tx_done  <= 1'b1;
                        tx_busy  <= 1'b0;
                        state    <= StIdle;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                    state   <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an integrated transmit FIFO. It generalises the single-shot din/tx_start/tx_done transmitter. Differences from that transmitter:
- configurable data width, parity mode and stop-bit count;
- a FIFO of configurable depth, so software can queue bytes back-to-back;
- full, level and overflow status.

The block sits between the bus-side write logic and the serial tx pin. It is a drop-in for the TX half of the UART.

Parameters:
CLK_FREQ_HZ  100_000_000  system clock frequency in Hz
BAUD_RATE  9600  serial bit rate; CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE (integer division); elaboration error if CLKS_PER_BIT < 2
DATA_WIDTH  8  data bits per frame, legal 5..9
PARITY  0  0 = none, 1 = odd, 2 = even
STOP_BITS  1  1 or 2
FIFO_DEPTH  16  FIFO entries, power of 2, >= 2

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
din  input  DATA_WIDTH  write data
wr_en  input  1  push din into FIFO this cycle
full  output  1  FIFO holds FIFO_DEPTH entries
fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
overflow  output  1  one-cycle pulse: write dropped because full
tx  output  1  serial line, idle high
tx_busy  output  1  frame in progress (FSM not IDLE)
tx_done  output  1  one-cycle pulse at end of each frame

Behaviour:
Reset values:
- rst asserted forces, asynchronously: tx=1, tx_busy=0, tx_done=0, overflow=0, full=0, fifo_count=0.
- FIFO pointers, baud counter, bit counter and FSM are cleared; the FSM returns to IDLE.
- Reset mid-frame abandons the frame. tx returns high immediately and no tx_done is produced.

FIFO:
- A write is accepted when wr_en=1 and full=0. Data is visible to the FSM on the next cycle.
- wr_en=1 with full=1: write dropped, overflow=1 for exactly that cycle. This holds even if a pop occurs in the same cycle.
- Simultaneous accepted write and pop: fifo_count unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- full = (fifo_count == FIFO_DEPTH), registered with the count.

FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1, tx_busy=0.
  - If fifo_count>0: pop head into the shift register, clear the baud counter, go to START.
  - tx goes low on the following cycle.
- START:
  - tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - tx = shift-register LSB, shifted right every CLKS_PER_BIT cycles.
  - After DATA_WIDTH bits: go to PARITY if PARITY != 0, else go to STOP.
- PARITY:
  - Odd parity: tx = ~^data. Even parity: tx = ^data. The total count of ones over data plus parity is odd or even respectively.
  - Lasts CLKS_PER_BIT cycles.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - On the last of these cycles the FSM registers tx_done=1 and returns to IDLE. tx_done is therefore high during the first IDLE cycle.
- Back-to-back frames: exactly one IDLE clock (tx=1) separates the stop bit from the next start bit.
- Frame length: (1 + DATA_WIDTH + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT clocks, plus 1 IDLE clock.
- tx_busy=1 in every non-IDLE state.

Other rules:
- din is sampled only when written to the FIFO. Later changes to din never affect a queued or in-flight frame.
- Unused upper shift bits are don't-care. Only DATA_WIDTH bits are serialised.

Test Plan:
1. CLK_FREQ_HZ=1_000_000, BAUD_RATE=100_000 (10 clks/bit), 8N1, write 0xA5 once ->
   - tx low 10 clks, then bits 1,0,1,0,0,1,0,1 (10 clks each), then high 10 clks;
   - tx_done pulses 1 cycle, 101 clks after the pop;
   - fifo_count goes 1→0 on the pop.
2. Same settings, PARITY=2 (even), STOP_BITS=2, write 0x03 -> parity bit 0, stop high 20 clks, frame 120 clks. Repeat with PARITY=1 (odd) -> parity bit 1.
3. FIFO_DEPTH=4, write 6 bytes on consecutive cycles while idle ->
   - first byte popped immediately;
   - next 4 bytes accepted; full=1 after the 5th write;
   - 6th write dropped with a 1-cycle overflow pulse.
   - Exactly 5 frames are sent, in order, each separated by one idle clock.
4. Assert rst for 1 cycle midway through the DATA state of a frame, with 2 bytes queued ->
   - tx=1 in the same cycle; fifo_count=0; no tx_done;
   - no further frames after reset release.
5. DATA_WIDTH=5, PARITY=1, write 0x1F -> 5 data bits all 1, parity bit 0, upper din bits ignored.
6. While a frame is in flight with fifo_count=FIFO_DEPTH-1: write coinciding with the pop of the next frame -> accepted, fifo_count unchanged, no overflow.
